// File: rtl/spi_mem_master.sv
// SPI mode-0 master for a serial memory: 16-bit header {wr, addr[14:0]} then data bytes.
// Define SPI_MEM_MASTER_BURST_EN to honour cmd_len; otherwise every transaction moves one byte.
module spi_mem_master #(
  parameter int unsigned DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [14:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [7:0]  wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic        SCK,
  output logic        MOSI,
  output logic        SSEL,
  input  logic        MISO
);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_ADDR, S_DATA, S_DESEL} state_e;

  localparam logic [8:0] PH_LAST    = 9'(DIV - 1);
  localparam logic [8:0] DESEL_LAST = 9'(2 * DIV - 1);

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        sck_q, sck_d;
  logic        ssel_q, ssel_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  bit_q, bit_d;
  logic        wr_q, wr_d;
  logic        wait_q, wait_d;
  logic        last_q, last_d;
  logic [7:0]  rx_q, rx_d;
  logic        rx_done_q, rx_done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        last_byte;
  logic        start_byte;

`ifdef SPI_MEM_MASTER_BURST_EN
  // Bytes still to transfer including the current one; 9 bits so len 255 means 256.
  logic [8:0]  rem_q, rem_d;
  assign last_byte = (rem_q == 9'd1);
`else
  logic        unused_len;
  assign unused_len = ^cmd_len;
  assign last_byte  = 1'b1;
`endif

  always_comb begin
    // NOTE: every next-state value gets its hold default first so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    sck_d       = sck_q;
    ssel_d      = ssel_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    wr_d        = wr_q;
    wait_d      = wait_q;
    last_d      = last_q;
    rx_d        = rx_q;
    rx_done_d   = 1'b0;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    start_byte  = 1'b0;
`ifdef SPI_MEM_MASTER_BURST_EN
    rem_d       = rem_q;
`endif

    // Received byte is published one cycle after its last bit was sampled.
    if (rx_done_q) begin
      rdata_d  = rx_q;
      rvalid_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = S_SEL;
          ssel_d  = 1'b0;
          sck_d   = 1'b0;
          cnt_d   = '0;
          shift_d = {cmd_wr, cmd_addr};
          wr_d    = cmd_wr;
          wait_d  = 1'b0;
          last_d  = 1'b0;
`ifdef SPI_MEM_MASTER_BURST_EN
          rem_d   = {1'b0, cmd_len} + 9'd1;
`endif
        end
      end

      S_SEL: begin
        if (cnt_q == PH_LAST) begin
          state_d = S_ADDR;
          sck_d   = 1'b1;
          cnt_d   = '0;
          bit_d   = 4'd15;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      S_ADDR, S_DATA: begin
        if (sck_q) begin
          if (cnt_q == PH_LAST) begin
            sck_d   = 1'b0;
            cnt_d   = '0;
            shift_d = shift_q << 1;
            if (bit_q != 4'd0) begin
              bit_d = bit_q - 4'd1;
            end else if (state_q == S_ADDR) begin
              state_d    = S_DATA;
              start_byte = 1'b1;
            end else if (last_byte) begin
              last_d = 1'b1;
            end else begin
              start_byte = 1'b1;
`ifdef SPI_MEM_MASTER_BURST_EN
              rem_d      = rem_q - 9'd1;
`endif
            end
            // A write byte is loaded on the falling edge that starts it; without data the low phase stalls.
            if (start_byte) begin
              bit_d = 4'd7;
              if (wr_q) begin
                if (wdata_valid) begin
                  wdata_ready = 1'b1;
                  shift_d     = {wdata, 8'h00};
                end else begin
                  wait_d = 1'b1;
                end
              end
            end
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end else if (wait_q) begin
          if (wdata_valid) begin
            wdata_ready = 1'b1;
            shift_d     = {wdata, 8'h00};
            wait_d      = 1'b0;
          end
        end else if (cnt_q == PH_LAST) begin
          cnt_d = '0;
          if (last_q) begin
            state_d = S_DESEL;
            ssel_d  = 1'b1;
            last_d  = 1'b0;
          end else begin
            sck_d = 1'b1;
            if (state_q == S_DATA && !wr_q) begin
              rx_d      = {rx_q[6:0], MISO};
              rx_done_d = (bit_q == 4'd0);
            end
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      S_DESEL: begin
        if (cnt_q == DESEL_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sck_q     <= 1'b0;
      ssel_q    <= 1'b1;
      shift_q   <= '0;
      bit_q     <= '0;
      wr_q      <= 1'b0;
      wait_q    <= 1'b0;
      last_q    <= 1'b0;
      rx_q      <= '0;
      rx_done_q <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
`ifdef SPI_MEM_MASTER_BURST_EN
      rem_q     <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sck_q     <= sck_d;
      ssel_q    <= ssel_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      wr_q      <= wr_d;
      wait_q    <= wait_d;
      last_q    <= last_d;
      rx_q      <= rx_d;
      rx_done_q <= rx_done_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
`ifdef SPI_MEM_MASTER_BURST_EN
      rem_q     <= rem_d;
`endif
    end
  end

  assign SCK         = sck_q;
  assign SSEL        = ssel_q;
  assign MOSI        = shift_q[15];
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;

endmodule

// File: tb/tb_spi_mem_master.sv
// Self-checking bench for spi_mem_master: directed vector table, reset abort, random traffic
// against a behavioural SPI memory responder and a reference memory array.
module tb_spi_mem_master;

  localparam int DIV = 4;
`ifdef SPI_MEM_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [14:0] cmd_addr;
  logic [7:0]  cmd_len, wdata, rdata;
  logic        wdata_valid, wdata_ready, rdata_valid;
  logic        SCK, MOSI, SSEL, miso;

  always #5 clk = ~clk;

  spi_mem_master #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid),
    .SCK(SCK), .MOSI(MOSI), .SSEL(SSEL), .MISO(miso)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [7:0] len);
    return BURST ? int'(len) + 1 : 1;
  endfunction

  // Device memory (the responder) and the bench's own expectation of its contents.
  logic [7:0] dev_mem [32768];
  logic [7:0] ref_mem [32768];
  logic [7:0] tx_data [256];

  // Behavioural SPI memory: mode 0, samples MOSI on rising SCK, shifts MISO on falling SCK.
  initial begin
    int bitn, pos;
    logic [15:0] hdr;
    logic [14:0] a;
    logic [7:0]  rx;
    logic        sck_prev;
    miso = 1'b0; bitn = 0; hdr = '0; a = '0; rx = '0; sck_prev = 1'b0;
    forever begin
      @(SCK or SSEL);
      if (SSEL) begin
        bitn = 0;
        miso = 1'b0;
      end else if (SCK && !sck_prev) begin
        if (bitn < 16) hdr = {hdr[14:0], MOSI};
        else           rx  = {rx[6:0], MOSI};
        bitn++;
        if (bitn == 16) a = hdr[14:0];
        else if (bitn > 16 && (bitn - 16) % 8 == 0) begin
          if (hdr[15]) dev_mem[a] = rx;
          a = a + 15'd1;
        end
      end else if (!SCK && sck_prev && bitn >= 16 && !hdr[15]) begin
        pos  = 7 - ((bitn - 16) % 8);
        miso = dev_mem[a][pos];
      end
      sck_prev = SCK;
    end
  end

  // Bus monitor, sampled on the falling clk edge.
  int   m_rises, m_wr_pulses, m_rv_pulses, m_ssel_low, m_desel;
  int   m_phase_err, m_mosi_err, m_rv_err, m_max_low;
  int   hi_len, lo_len, cyc_since_rise;
  bit   allow_stall;
  bit   m_bits[$];
  logic [7:0] m_rd[$];

  task automatic mon_clear();
    m_rises = 0; m_wr_pulses = 0; m_rv_pulses = 0; m_ssel_low = 0; m_desel = 0;
    m_phase_err = 0; m_mosi_err = 0; m_rv_err = 0; m_max_low = 0;
    hi_len = 0; lo_len = 0; cyc_since_rise = 100;
    m_bits.delete();
    m_rd.delete();
  endtask

  initial begin
    logic sck_p, ssel_p, mosi_p;
    sck_p = 1'b0; ssel_p = 1'b1; mosi_p = 1'b0; allow_stall = 1'b0;
    mon_clear();
    forever begin
      @(negedge clk);
      if (SCK && !sck_p) begin
        if (allow_stall ? (lo_len < DIV) : (lo_len != DIV)) m_phase_err++;
        lo_len = 0;
        m_rises++;
        m_bits.push_back(MOSI);
        cyc_since_rise = 0;
      end else begin
        cyc_since_rise++;
      end
      if (!SCK && sck_p) begin
        if (hi_len != DIV) m_phase_err++;
        hi_len = 0;
      end
      if (SCK) hi_len++;
      if (!SSEL && !SCK) begin
        lo_len++;
        if (lo_len > m_max_low) m_max_low = lo_len;
      end
      if (SSEL && !ssel_p) begin
        if (allow_stall ? (lo_len < DIV) : (lo_len != DIV)) m_phase_err++;
        lo_len = 0;
      end
      if (SCK && MOSI !== mosi_p) m_mosi_err++;
      if (!SSEL) m_ssel_low++;
      if (SSEL && !cmd_ready) m_desel++;
      if (wdata_ready) m_wr_pulses++;
      if (rdata_valid) begin
        m_rv_pulses++;
        m_rd.push_back(rdata);
        if (cyc_since_rise != 1) m_rv_err++;
      end
      sck_p = SCK; ssel_p = SSEL; mosi_p = MOSI;
    end
  end

  function automatic logic [7:0] mon_byte(input int start);
    logic [7:0] b = 'x;
    if (m_bits.size() >= start + 8)
      for (int j = 0; j < 8; j++) b = {b[6:0], m_bits[start + j]};
    return b;
  endfunction

  function automatic logic [15:0] mon_hdr();
    logic [15:0] h = 'x;
    if (m_bits.size() >= 16)
      for (int j = 0; j < 16; j++) h = {h[14:0], m_bits[j]};
    return h;
  endfunction

  // One complete transaction with expectations taken from the reference model.
  task automatic run_txn(input string tag, input logic wr, input logic [14:0] addr,
                         input logic [7:0] len, input int stall_byte, input int stall_cyc);
    int nb, budget, c, nz;
    bit done;
    logic [7:0] got;
    nb = nbytes_of(len);
    budget = DIV * (2 * (16 + 8 * nb) + 4) + stall_cyc + 200;
    mon_clear();
    allow_stall = (stall_byte > 0 && stall_byte < nb);
    @(negedge clk);
    cmd_wr = wr; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    wdata = tx_data[0]; wdata_valid = wr;
    c = 0;
    while (!cmd_ready && c < budget) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_wr = ~wr; cmd_addr = ~addr; cmd_len = ~len;
    done = 1'b0;
    fork
      begin
        if (wr) begin
          for (int i = 0; i < nb && !done; i++) begin
            wdata = tx_data[i];
            if (i == stall_byte) begin
              wdata_valid = 1'b0;
              while (m_rises < 16 + 8 * i && !done) @(negedge clk);
              repeat (stall_cyc + DIV) @(negedge clk);
            end
            wdata_valid = 1'b1;
            while (!done) begin
              @(negedge clk);
              if (wdata_ready) break;
            end
            @(posedge clk); #1;
          end
          wdata_valid = 1'b0;
        end
      end
      begin
        c = 0;
        while (c < budget) begin
          @(negedge clk); c++;
          if (cmd_ready) break;
        end
        done = 1'b1;
      end
    join
    check({tag, ".complete"}, cmd_ready, 1);
    check({tag, ".hdr"}, mon_hdr(), {wr, addr});
    check({tag, ".sck_periods"}, m_rises, 16 + 8 * nb);
    check({tag, ".wdata_ready_pulses"}, m_wr_pulses, wr ? nb : 0);
    check({tag, ".rdata_valid_pulses"}, m_rv_pulses, wr ? 0 : nb);
    if (wr) begin
      for (int i = 0; i < nb; i++) begin
        check($sformatf("%s.mosi_byte%0d", tag, i), mon_byte(16 + 8 * i), tx_data[i]);
        ref_mem[15'(int'(addr) + i)] = tx_data[i];
      end
    end else begin
      nz = 0;
      for (int i = 0; i < nb; i++) if (mon_byte(16 + 8 * i) !== 8'h00) nz++;
      check({tag, ".mosi_zero_in_read"}, nz, 0);
      for (int i = 0; i < nb; i++) begin
        got = (i < m_rd.size()) ? m_rd[i] : 8'hxx;
        check($sformatf("%s.rdata%0d", tag, i), got, ref_mem[15'(int'(addr) + i)]);
      end
    end
    if (allow_stall) begin
      check({tag, ".ssel_low_min"}, m_ssel_low >= DIV * (1 + 2 * (16 + 8 * nb)), 1);
      check({tag, ".stall_low_len"}, m_max_low >= stall_cyc, 1);
    end else begin
      check({tag, ".ssel_low"}, m_ssel_low, DIV * (1 + 2 * (16 + 8 * nb)));
    end
    check({tag, ".desel_hold"}, m_desel >= 2 * DIV, 1);
    check({tag, ".phase_len_errs"}, m_phase_err, 0);
    check({tag, ".mosi_in_high_errs"}, m_mosi_err, 0);
    check({tag, ".rvalid_timing_errs"}, m_rv_err, 0);
    allow_stall = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [14:0] addr;
    logic [7:0]  len;
    logic [31:0] wbytes;
    int          stall_byte;
    int          stall_cyc;
    logic [15:0] exp_hdr;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int c, nb;
    logic [7:0] got;

    vecs[0] = '{1'b1, 15'h1234, 8'd0,   32'h0000_00A5, -1, 0,  16'h9234, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 15'h0010, 8'd2,   32'h0,         -1, 0,  16'h0010, 1'b1, 32'h0033_2211};
    vecs[2] = '{1'b1, 15'h0300, 8'd1,   32'h0000_C35A,  1, 20, 16'h8300, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 15'h0200, 8'd3,   32'hEFBE_ADDE, -1, 0,  16'h8200, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 15'h0200, 8'd3,   32'h0,         -1, 0,  16'h0200, 1'b1, 32'hEFBE_ADDE};
    vecs[5] = '{1'b0, 15'h0400, 8'd255, 32'h0,         -1, 0,  16'h0400, 1'b0, 32'h0};

    for (int i = 0; i < 32768; i++) begin
      dev_mem[i] = 8'(i * 37 + 11);
      ref_mem[i] = 8'(i * 37 + 11);
    end
    dev_mem[16] = 8'h11; dev_mem[17] = 8'h22; dev_mem[18] = 8'h33;
    ref_mem[16] = 8'h11; ref_mem[17] = 8'h22; ref_mem[18] = 8'h33;

    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata = '0; wdata_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.SCK", SCK, 0);
    check("reset.MOSI", MOSI, 0);
    check("reset.SSEL", SSEL, 1);
    check("reset.cmd_ready", cmd_ready, 1);
    check("reset.wdata_ready", wdata_ready, 0);
    check("reset.rdata_valid", rdata_valid, 0);
    check("reset.rdata", rdata, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) tx_data[i] = vecs[k].wbytes[8 * i +: 8];
      run_txn($sformatf("vec%0d", k), vecs[k].wr, vecs[k].addr, vecs[k].len,
              vecs[k].stall_byte, vecs[k].stall_cyc);
      check($sformatf("vec%0d.table_hdr", k), mon_hdr(), vecs[k].exp_hdr);
      if (vecs[k].chk_rd) begin
        nb = nbytes_of(vecs[k].len);
        for (int i = 0; i < nb && i < 4; i++) begin
          got = (i < m_rd.size()) ? m_rd[i] : 8'hxx;
          check($sformatf("vec%0d.table_rdata%0d", k, i), got, vecs[k].exp_rd[8 * i +: 8]);
        end
      end
    end

    // Reset in the middle of header bit 7 must abort at once and leave the bus idle.
    mon_clear();
    @(negedge clk);
    cmd_wr = 1'b0; cmd_addr = 15'h0ABC; cmd_len = 8'd3; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    c = 0;
    while (m_rises < 9 && c < 2000) begin @(negedge clk); c++; end
    check("abort.reached_bit7", m_rises >= 9, 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort.SSEL", SSEL, 1);
    check("abort.SCK", SCK, 0);
    check("abort.MOSI", MOSI, 0);
    check("abort.cmd_ready", cmd_ready, 1);
    check("abort.wdata_ready", wdata_ready, 0);
    check("abort.rdata_valid", rdata_valid, 0);
    check("abort.rdata", rdata, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_clear();
    repeat (200) @(negedge clk);
    check("abort.no_rvalid", m_rv_pulses, 0);
    check("abort.no_wready", m_wr_pulses, 0);
    check("abort.no_ssel_low", m_ssel_low, 0);
    check("abort.no_sck", m_rises, 0);
    run_txn("after_abort", 1'b0, 15'h0010, 8'd0, -1, 0);

    // Random traffic over a small window so reads see earlier writes.
    for (int t = 0; t < 24; t++) begin
      logic        rwr;
      logic [14:0] raddr;
      logic [7:0]  rlen;
      rwr   = 1'($urandom_range(0, 1));
      raddr = 15'(15'h1000 + $urandom_range(0, 63));
      rlen  = 8'($urandom_range(0, 5));
      for (int i = 0; i < 8; i++) tx_data[i] = 8'($urandom);
      run_txn($sformatf("rnd%0d", t), rwr, raddr, rlen, -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
